dual_issue_ctrl: RTL and testbench

DUAL_ISSUE_CTRL -- requirements
Module: dual_issue_ctrl

---
 rtl/isa_pkg.sv | 31 +++
 rtl/reg_use_decode.sv | 47 ++++
 rtl/dual_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_dual_issue_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants, issue-FSM state encoding and a saturating counter helper
// used by the dual-issue control slice.
package isa_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0]  REG_STATUS = 5'd30;
  localparam logic [4:0]  REG_LINK   = 5'd31;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_PAIR     = 2'd0,
    ST_SPLIT    = 2'd1,
    ST_LU_STALL = 2'd2
  } issue_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Per-slot register read/write-set decode; enables are pre-masked with valid
// and with register 0 so downstream comparators never see r0 hazards.
module reg_use_decode
  import isa_pkg::*;
(
  input  logic       valid,
  input  logic [4:0] op,
  input  logic [4:0] rd,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic [4:0] src_a,
  output logic       src_a_en,
  output logic [4:0] src_b,
  output logic       src_b_en,
  output logic [4:0] dst,
  output logic       dst_en,
  output logic       is_mem,
  output logic       is_ctrl
);

  always_comb begin
    src_a   = 5'd0;
    src_b   = 5'd0;
    dst     = 5'd0;
    is_mem  = 1'b0;
    is_ctrl = 1'b0;
    case (op)
      OP_RTYPE: begin src_a = rs; src_b = rt; dst = rd; end
      OP_ADDI:  begin src_a = rs; dst = rd; end
      OP_LW:    begin src_a = rs; dst = rd; is_mem = 1'b1; end
      OP_SW:    begin src_a = rd; src_b = rs; is_mem = 1'b1; end
      OP_BNE,
      OP_BLT:   begin src_a = rd; src_b = rs; is_ctrl = 1'b1; end
      OP_JR:    begin src_a = rd; is_ctrl = 1'b1; end
      OP_BEX:   begin src_a = REG_STATUS; is_ctrl = 1'b1; end
      OP_J:     is_ctrl = 1'b1;
      OP_JAL:   begin dst = REG_LINK; is_ctrl = 1'b1; end
      OP_SETX:  dst = REG_STATUS;
      default:  ;
    endcase
  end

  assign src_a_en = valid && (src_a != 5'd0);
  assign src_b_en = valid && (src_b != 5'd0);
  assign dst_en   = valid && (dst != 5'd0);

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue steering for the FD->DX boundary: pairs, splits or bubbles the two
// FD slots, with zero-latency issue outputs and saturating performance counters.
module dual_issue_ctrl
  import isa_pkg::*;
(
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        fd_valid0,
  input  logic        fd_valid1,
  input  logic [4:0]  fd_op0,
  input  logic [4:0]  fd_op1,
  input  logic [4:0]  fd_rd0,
  input  logic [4:0]  fd_rs0,
  input  logic [4:0]  fd_rt0,
  input  logic [4:0]  fd_rd1,
  input  logic [4:0]  fd_rs1,
  input  logic [4:0]  fd_rt1,
  input  logic        dx_load0,
  input  logic        dx_load1,
  input  logic [4:0]  dx_rd0,
  input  logic [4:0]  dx_rd1,
  input  logic        hold_in,
  input  logic        flush,
  output logic        dx_we0,
  output logic        dx_we1,
  output logic        issue0,
  output logic        issue1,
  output logic        fd_stall,
  output logic [15:0] split_cnt,
  output logic [15:0] stall_cnt
);

  issue_state_e state_reg, state_next;
  logic [15:0]  split_cnt_reg, stall_cnt_reg;
  logic         split_evt, bubble_evt;

  logic [1:0] valid_s, src_a_en, src_b_en, dst_en, is_mem, is_ctrl, lu_slot;
  logic [4:0] op_s [2];
  logic [4:0] rd_s [2];
  logic [4:0] rs_s [2];
  logic [4:0] rt_s [2];
  logic [4:0] src_a [2];
  logic [4:0] src_b [2];
  logic [4:0] dst [2];

  assign valid_s = {fd_valid1, fd_valid0};
  assign op_s[0] = fd_op0;
  assign op_s[1] = fd_op1;
  assign rd_s[0] = fd_rd0;
  assign rd_s[1] = fd_rd1;
  assign rs_s[0] = fd_rs0;
  assign rs_s[1] = fd_rs1;
  assign rt_s[0] = fd_rt0;
  assign rt_s[1] = fd_rt1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    reg_use_decode u_dec (
      .valid    (valid_s[gi]),
      .op       (op_s[gi]),
      .rd       (rd_s[gi]),
      .rs       (rs_s[gi]),
      .rt       (rt_s[gi]),
      .src_a    (src_a[gi]),
      .src_a_en (src_a_en[gi]),
      .src_b    (src_b[gi]),
      .src_b_en (src_b_en[gi]),
      .dst      (dst[gi]),
      .dst_en   (dst_en[gi]),
      .is_mem   (is_mem[gi]),
      .is_ctrl  (is_ctrl[gi])
    );

    // Source enables already exclude r0, so a match implies a nonzero load target.
    assign lu_slot[gi] =
        (dx_load0 && ((src_a_en[gi] && src_a[gi] == dx_rd0) ||
                      (src_b_en[gi] && src_b[gi] == dx_rd0))) ||
        (dx_load1 && ((src_a_en[gi] && src_a[gi] == dx_rd1) ||
                      (src_b_en[gi] && src_b[gi] == dx_rd1)));
  end

  logic load_use, raw_waw, pair_conflict;

  assign load_use = |lu_slot;
  assign raw_waw  = dst_en[0] && ((src_a_en[1] && src_a[1] == dst[0]) ||
                                  (src_b_en[1] && src_b[1] == dst[0]) ||
                                  (dst_en[1]   && dst[1]   == dst[0]));
  assign pair_conflict = fd_valid0 && fd_valid1 &&
                         (raw_waw || (is_mem[0] && is_mem[1]) || is_ctrl[0]);

  always_comb begin
    state_next = state_reg;
    issue0     = 1'b0;
    issue1     = 1'b0;
    fd_stall   = 1'b0;
    dx_we0     = 1'b1;
    dx_we1     = 1'b1;
    split_evt  = 1'b0;
    bubble_evt = 1'b0;
    if (flush) begin
      state_next = ST_PAIR;
    end else begin
      case (state_reg)
        ST_SPLIT: begin
          if (lu_slot[1]) begin
            fd_stall   = 1'b1;
            bubble_evt = 1'b1;
          end else begin
            issue1     = 1'b1;
            state_next = ST_PAIR;
          end
        end
        // LU_STALL re-evaluates as PAIR once the bubble has refreshed DX.
        default: begin
          if (load_use) begin
            fd_stall   = 1'b1;
            bubble_evt = 1'b1;
            state_next = ST_LU_STALL;
          end else if (pair_conflict) begin
            issue0     = 1'b1;
            fd_stall   = 1'b1;
            split_evt  = 1'b1;
            state_next = ST_SPLIT;
          end else begin
            issue0     = fd_valid0;
            issue1     = fd_valid1;
            state_next = ST_PAIR;
          end
        end
      endcase
      if (hold_in) begin
        dx_we0     = 1'b0;
        dx_we1     = 1'b0;
        fd_stall   = 1'b1;
        state_next = state_reg;
        split_evt  = 1'b0;
        bubble_evt = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_reg     <= ST_PAIR;
      split_cnt_reg <= 16'd0;
      stall_cnt_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (split_evt)  split_cnt_reg <= sat_inc(split_cnt_reg);
      if (bubble_evt) stall_cnt_reg <= sat_inc(stall_cnt_reg);
    end
  end

  assign split_cnt = split_cnt_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard bench for dual_issue_ctrl: each cycle's hand-derived expectation is
// queued as the stimulus is applied and compared once the outputs have settled.
module tb_dual_issue_ctrl;
  import isa_pkg::*;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        fd_valid0 = 1'b0, fd_valid1 = 1'b0;
  logic [4:0]  fd_op0 = '0, fd_op1 = '0;
  logic [4:0]  fd_rd0 = '0, fd_rs0 = '0, fd_rt0 = '0;
  logic [4:0]  fd_rd1 = '0, fd_rs1 = '0, fd_rt1 = '0;
  logic        dx_load0 = 1'b0, dx_load1 = 1'b0;
  logic [4:0]  dx_rd0 = '0, dx_rd1 = '0;
  logic        hold_in = 1'b0, flush = 1'b0;
  logic        dx_we0, dx_we1, issue0, issue1, fd_stall;
  logic [15:0] split_cnt, stall_cnt;

  dual_issue_ctrl dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .fd_valid0(fd_valid0), .fd_valid1(fd_valid1),
    .fd_op0(fd_op0), .fd_op1(fd_op1),
    .fd_rd0(fd_rd0), .fd_rs0(fd_rs0), .fd_rt0(fd_rt0),
    .fd_rd1(fd_rd1), .fd_rs1(fd_rs1), .fd_rt1(fd_rt1),
    .dx_load0(dx_load0), .dx_load1(dx_load1),
    .dx_rd0(dx_rd0), .dx_rd1(dx_rd1),
    .hold_in(hold_in), .flush(flush),
    .dx_we0(dx_we0), .dx_we1(dx_we1),
    .issue0(issue0), .issue1(issue1), .fd_stall(fd_stall),
    .split_cnt(split_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    bit          chk_issue;
    logic        i0, i1, st, we;
    logic [15:0] sc, lc;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic slots(input logic v0, input logic [4:0] op0, rd0, rs0, rt0,
                       input logic v1, input logic [4:0] op1, rd1, rs1, rt1);
    fd_valid0 = v0; fd_op0 = op0; fd_rd0 = rd0; fd_rs0 = rs0; fd_rt0 = rt0;
    fd_valid1 = v1; fd_op1 = op1; fd_rd1 = rd1; fd_rs1 = rs1; fd_rt1 = rt1;
  endtask

  task automatic dx(input logic l0, input logic [4:0] r0, input logic l1, input logic [4:0] r1);
    dx_load0 = l0; dx_rd0 = r0; dx_load1 = l1; dx_rd1 = r1;
  endtask

  // Called a little after a falling edge with inputs already applied.
  task automatic step(input string tag, input bit ci, input logic i0, i1, st, we,
                      input logic [15:0] sc, lc);
    exp_t e;
    e.tag = tag; e.chk_issue = ci; e.i0 = i0; e.i1 = i1; e.st = st; e.we = we;
    e.sc = sc; e.lc = lc;
    sb_q.push_back(e);
    #2;
    e = sb_q.pop_front();
    $display("[TB] %s: issue=%b%b fd_stall=%b we=%b%b split=%0d stall=%0d",
             e.tag, issue0, issue1, fd_stall, dx_we0, dx_we1, split_cnt, stall_cnt);
    if (e.chk_issue) begin
      check_eq({e.tag, ".issue0"}, 32'(issue0), 32'(e.i0));
      check_eq({e.tag, ".issue1"}, 32'(issue1), 32'(e.i1));
    end
    check_eq({e.tag, ".fd_stall"}, 32'(fd_stall), 32'(e.st));
    check_eq({e.tag, ".dx_we0"}, 32'(dx_we0), 32'(e.we));
    check_eq({e.tag, ".dx_we1"}, 32'(dx_we1), 32'(e.we));
    check_eq({e.tag, ".split_cnt"}, 32'(split_cnt), 32'(e.sc));
    check_eq({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.lc));
    @(negedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 ctrl_reset = 1'b0;
    @(negedge clock); #1;
    step("reset", 1, 0, 0, 0, 1, 16'd0, 16'd0);
    ctrl_reset = 1'b1;

    // Independent ALU pair issues together.
    slots(1, OP_RTYPE, 5'd1, 5'd2, 5'd3, 1, OP_RTYPE, 5'd4, 5'd5, 5'd6);
    step("pair_add_sub", 1, 1, 1, 0, 1, 16'd0, 16'd0);

    // RAW on slot 0's write register splits the pair.
    slots(1, OP_ADDI, 5'd1, 5'd2, 5'd0, 1, OP_RTYPE, 5'd3, 5'd1, 5'd4);
    step("raw_split_c1", 1, 1, 0, 1, 1, 16'd0, 16'd0);
    step("raw_split_c2", 1, 0, 1, 0, 1, 16'd1, 16'd0);

    // Load-use against DX lane 1, one bubble then pair.
    slots(1, OP_RTYPE, 5'd2, 5'd7, 5'd8, 1, OP_RTYPE, 5'd9, 5'd10, 5'd11);
    dx(0, 5'd0, 1, 5'd7);
    step("lu_bubble", 1, 0, 0, 1, 1, 16'd1, 16'd0);
    dx(0, 5'd0, 0, 5'd0);
    step("lu_reissue", 1, 1, 1, 0, 1, 16'd1, 16'd1);

    // Flush while in SPLIT drops slot 1.
    slots(1, OP_LW, 5'd5, 5'd2, 5'd0, 1, OP_RTYPE, 5'd6, 5'd5, 5'd1);
    step("flush_c1", 1, 1, 0, 1, 1, 16'd1, 16'd1);
    flush = 1'b1;
    step("flush_split", 1, 0, 0, 0, 1, 16'd2, 16'd1);
    flush = 1'b0;
    slots(1, OP_RTYPE, 5'd1, 5'd2, 5'd3, 1, OP_RTYPE, 5'd4, 5'd5, 5'd6);
    step("flush_after", 1, 1, 1, 0, 1, 16'd2, 16'd1);

    // Two memory ops conflict; hold for 3 cycles inside SPLIT.
    slots(1, OP_SW, 5'd1, 5'd2, 5'd0, 1, OP_LW, 5'd3, 5'd4, 5'd0);
    step("mem_split_c1", 1, 1, 0, 1, 1, 16'd2, 16'd1);
    hold_in = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("hold_%0d", i), 0, 0, 0, 1, 0, 16'd3, 16'd1);
    hold_in = 1'b0;
    step("hold_release", 1, 0, 1, 0, 1, 16'd3, 16'd1);

    // Control transfer in slot 0 forces a split.
    slots(1, OP_BNE, 5'd1, 5'd2, 5'd0, 1, OP_RTYPE, 5'd3, 5'd4, 5'd5);
    step("ctrl_split_c1", 1, 1, 0, 1, 1, 16'd3, 16'd1);
    step("ctrl_split_c2", 1, 0, 1, 0, 1, 16'd4, 16'd1);

    // sw in slot 1 reads its rd field, hitting a lw in DX lane 0.
    slots(1, OP_RTYPE, 5'd1, 5'd2, 5'd3, 1, OP_SW, 5'd9, 5'd4, 5'd0);
    dx(1, 5'd9, 0, 5'd0);
    step("lu_sw_rd", 1, 0, 0, 1, 1, 16'd4, 16'd1);
    dx(0, 5'd0, 0, 5'd0);
    step("lu_sw_reissue", 1, 1, 1, 0, 1, 16'd4, 16'd2);

    // Register 0 never causes a hazard or conflict.
    slots(1, OP_RTYPE, 5'd0, 5'd0, 5'd0, 1, OP_RTYPE, 5'd5, 5'd0, 5'd0);
    dx(1, 5'd0, 0, 5'd0);
    step("r0_no_hazard", 1, 1, 1, 0, 1, 16'd4, 16'd2);

    // Flush beats a load-use hazard and does not count a bubble.
    slots(1, OP_RTYPE, 5'd1, 5'd2, 5'd3, 1, OP_RTYPE, 5'd4, 5'd5, 5'd6);
    dx(1, 5'd2, 0, 5'd0);
    flush = 1'b1;
    step("flush_over_lu", 1, 0, 0, 0, 1, 16'd4, 16'd2);
    flush = 1'b0;
    dx(0, 5'd0, 0, 5'd0);
    step("flush_lu_after", 1, 1, 1, 0, 1, 16'd4, 16'd2);

    // Flush beats hold and a pair conflict.
    slots(1, OP_LW, 5'd5, 5'd2, 5'd0, 1, OP_RTYPE, 5'd6, 5'd5, 5'd1);
    hold_in = 1'b1; flush = 1'b1;
    step("flush_over_hold", 1, 0, 0, 0, 1, 16'd4, 16'd2);
    hold_in = 1'b0; flush = 1'b0;

    // Load-use on slot 1 while in SPLIT keeps SPLIT for a bubble.
    step("split_lu_c1", 1, 1, 0, 1, 1, 16'd4, 16'd2);
    dx(1, 5'd5, 0, 5'd0);
    step("split_lu_c2", 1, 0, 0, 1, 1, 16'd5, 16'd2);
    dx(0, 5'd0, 0, 5'd0);
    step("split_lu_c3", 1, 0, 1, 0, 1, 16'd5, 16'd3);

    // Saturation of split_cnt.
    force dut.split_cnt_reg = 16'hFFFE;
    #1 release dut.split_cnt_reg;
    slots(1, OP_ADDI, 5'd1, 5'd2, 5'd0, 1, OP_RTYPE, 5'd3, 5'd1, 5'd4);
    step("sat_c1", 1, 1, 0, 1, 1, 16'hFFFE, 16'd3);
    step("sat_c2", 1, 0, 1, 0, 1, 16'hFFFF, 16'd3);
    step("sat_c3", 1, 1, 0, 1, 1, 16'hFFFF, 16'd3);
    step("sat_c4", 1, 0, 1, 0, 1, 16'hFFFF, 16'd3);

    // Reset asserted mid-SPLIT drops the pending slot-1 issue.
    step("rst_split_c1", 1, 1, 0, 1, 1, 16'hFFFF, 16'd3);
    ctrl_reset = 1'b0;
    step("rst_in_split", 1, 1, 0, 1, 1, 16'd0, 16'd0);
    ctrl_reset = 1'b1;
    slots(0, OP_RTYPE, 5'd0, 5'd0, 5'd0, 0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    step("rst_after", 1, 0, 0, 0, 1, 16'd0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
